// File: rtl/qam_slicer_ber_pkg.sv
// rtl/qam_slicer_ber_pkg.sv - shared mode constants, FSM states and popcount helper for qam_slicer_ber
package qam_pkg;

  localparam logic MODE_QPSK  = 1'b0;
  localparam logic MODE_16QAM = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/qam_slicer_ber_ref_bit_fifo.sv
// rtl/qam_slicer_ber_ref_bit_fifo.sv - sync reference-bit FIFO with full/empty flags and drop-on-full
module ref_bit_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];

  // storage write; entries beyond the pointers are never read
  always_ff @(posedge clk) begin
    if (reset && !flush && push_ok) mem[wr_ptr] <= wr_data;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qam_slicer_ber.sv
// rtl/qam_slicer_ber.sv - QPSK/16-QAM hard slicer with reference alignment and BER counters (option: QAM_SLICER_PERBIT_ERR_EN)
module qam_slicer_ber
  import qam_pkg::*;
#(
  parameter int BI         = 24,
  parameter int AMP        = 1048576,
  parameter int NSYM       = 320000,
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic          tx_valid,
  input  logic [3:0]    tx_bits,
  input  logic          rx_valid,
  input  logic [BI-1:0] rx_real,
  input  logic [BI-1:0] rx_imag,
  output logic          dec_valid,
  output logic [3:0]    dec_bits,
  output logic [CW-1:0] sym_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          busy,
  output logic          done,
  output logic          fifo_ovf,
  output logic          fifo_unf
`ifdef QAM_SLICER_PERBIT_ERR_EN
  ,
  output logic [4*CW-1:0] err_bit_cnt
`endif
);

  localparam logic [BI:0]   THR     = (BI+1)'(2 * AMP);
  localparam logic [CW-1:0] NSYM_M1 = CW'(NSYM - 1);

  state_t        state;
  state_t        state_nxt;
  logic          mode_q;
  logic          start_go;
  logic          pop_req;
  logic          count_now;
  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    ref_head;
  logic [BI:0]   ext_i;
  logic [BI:0]   ext_q;
  logic [BI:0]   abs_i;
  logic [BI:0]   abs_q;
  logic [3:0]    slice_bits;
  logic [3:0]    s1_ref;
  logic          s1_count;
  logic          s2_en;
  logic [3:0]    err_mask;
  logic [3:0]    diff;
  logic [2:0]    err_add;
  logic [CW:0]   err_sum;

  assign start_go  = start && (state != RUN);
  assign pop_req   = rx_valid && (state == RUN);
  assign count_now = pop_req && !fifo_empty;

  ref_bit_fifo #(
    .W     (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (start_go),
    .push    (tx_valid),
    .wr_data (tx_bits),
    .pop     (pop_req),
    .rd_data (ref_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: a run ends when the symbol reaching NSYM is counted
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (s1_count && sym_cnt == NSYM_M1) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // mode is held for the whole run
  always_ff @(posedge clk) begin
    if (!reset)        mode_q <= MODE_QPSK;
    else if (start_go) mode_q <= mode;
  end

  // magnitudes in BI+1 bits so the most negative sample does not wrap
  assign ext_i = {rx_real[BI-1], rx_real};
  assign ext_q = {rx_imag[BI-1], rx_imag};
  assign abs_i = rx_real[BI-1] ? (~ext_i + (BI+1)'(1)) : ext_i;
  assign abs_q = rx_imag[BI-1] ? (~ext_q + (BI+1)'(1)) : ext_q;

  // hard decision: sign bit gives the half-plane, zero counts as positive
  always_comb begin
    slice_bits = '0;
    if (mode_q == MODE_16QAM) slice_bits = {rx_real[BI-1], abs_i >= THR, rx_imag[BI-1], abs_q >= THR};
    else                      slice_bits = {2'b00, rx_real[BI-1], rx_imag[BI-1]};
  end

  // stage 1: decision plus the aligned reference bits
  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_valid <= 1'b0;
      dec_bits  <= '0;
      s1_ref    <= '0;
      s1_count  <= 1'b0;
    end else begin
      dec_valid <= rx_valid;
      s1_count  <= count_now;
      if (rx_valid) begin
        dec_bits <= slice_bits;
        s1_ref   <= ref_head;
      end
    end
  end

  assign s2_en    = s1_count && (state == RUN);
  assign err_mask = (mode_q == MODE_QPSK) ? 4'h3 : 4'hF;
  assign diff     = (dec_bits ^ s1_ref) & err_mask;
  assign err_add  = popcount4(diff);
  assign err_sum  = {1'b0, err_cnt} + (CW+1)'(err_add);

  // stage 2: saturating symbol and bit-error counters, frozen outside RUN
  always_ff @(posedge clk) begin
    if (!reset || start_go) begin
      sym_cnt <= '0;
      err_cnt <= '0;
    end else if (s2_en) begin
      if (sym_cnt != '1) sym_cnt <= sym_cnt + CW'(1);
      err_cnt <= err_sum[CW] ? '1 : err_sum[CW-1:0];
    end
  end

  // sticky FIFO fault flags, cleared when a run starts
  always_ff @(posedge clk) begin
    if (!reset || start_go) begin
      fifo_ovf <= 1'b0;
      fifo_unf <= 1'b0;
    end else begin
      if (tx_valid && fifo_full && !count_now) fifo_ovf <= 1'b1;
      if (pop_req && fifo_empty)               fifo_unf <= 1'b1;
    end
  end

`ifdef QAM_SLICER_PERBIT_ERR_EN
  logic [CW-1:0] pb_cnt [4];

  assign err_bit_cnt = {pb_cnt[3], pb_cnt[2], pb_cnt[1], pb_cnt[0]};

  // per-bit-position error counters, cleared and frozen alongside err_cnt
  always_ff @(posedge clk) begin
    if (!reset || start_go) begin
      for (int b = 0; b < 4; b++) pb_cnt[b] <= '0;
    end else if (s2_en) begin
      for (int b = 0; b < 4; b++) begin
        if (diff[b] && pb_cnt[b] != '1) pb_cnt[b] <= pb_cnt[b] + CW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_qam_slicer_ber.sv
// tb/tb_qam_slicer_ber.sv - scoreboard bench for qam_slicer_ber with a queue-based reference model
module tb_qam_slicer_ber;

  localparam int BI    = 24;
  localparam int AMP   = 1048576;
  localparam int NSYM  = 20;
  localparam int CW    = 32;
  localparam int DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic                 mode = 1'b0;
  logic                 tx_valid = 1'b0;
  logic [3:0]           tx_bits = '0;
  logic                 rx_valid = 1'b0;
  logic signed [BI-1:0] rx_real = '0;
  logic signed [BI-1:0] rx_imag = '0;
  logic                 dec_valid;
  logic [3:0]           dec_bits;
  logic [CW-1:0]        sym_cnt;
  logic [CW-1:0]        err_cnt;
  logic                 busy;
  logic                 done;
  logic                 fifo_ovf;
  logic                 fifo_unf;
`ifdef QAM_SLICER_PERBIT_ERR_EN
  logic [4*CW-1:0]      err_bit_cnt;
`endif

  qam_slicer_ber #(
    .BI         (BI),
    .AMP        (AMP),
    .NSYM       (NSYM),
    .FIFO_DEPTH (DEPTH),
    .CW         (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .tx_valid  (tx_valid),
    .tx_bits   (tx_bits),
    .rx_valid  (rx_valid),
    .rx_real   (rx_real),
    .rx_imag   (rx_imag),
    .dec_valid (dec_valid),
    .dec_bits  (dec_bits),
    .sym_cnt   (sym_cnt),
    .err_cnt   (err_cnt),
    .busy      (busy),
    .done      (done),
    .fifo_ovf  (fifo_ovf),
    .fifo_unf  (fifo_unf)
`ifdef QAM_SLICER_PERBIT_ERR_EN
    ,
    .err_bit_cnt (err_bit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  logic [3:0] ref_q[$];
  logic [3:0] exp_q[$];
  bit         m_run, m_done, m_mode, m_ovf, m_unf;
  longint     m_sym, m_err;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] slice(input bit m16, input longint i, input longint q);
    longint ai, aq;
    ai = (i < 0) ? -i : i;
    aq = (q < 0) ? -q : q;
    if (!m16) return {2'b00, i < 0, q < 0};
    return {i < 0, ai >= 2 * AMP, q < 0, aq >= 2 * AMP};
  endfunction

  function automatic int nerr(input logic [3:0] d, input logic [3:0] r, input bit m16);
    int n = 0;
    for (int b = 0; b < 4; b++) if ((m16 || b < 2) && d[b] != r[b]) n++;
    return n;
  endfunction

  function automatic int pick();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 2 * AMP;
      2:       return -2 * AMP;
      3:       return 2 * AMP - 1;
      4:       return -2 * AMP + 1;
      5:       return -8388608;
      6:       return 8388607;
      default: return int'($urandom_range(0, 16777215)) - 8388608;
    endcase
  endfunction

  // reference model: one call per driven cycle, sees that cycle's inputs
  task automatic model_step();
    logic [3:0] d, r;
    if (!reset) begin
      m_run = 0; m_done = 0; m_mode = 0; m_ovf = 0; m_unf = 0;
      m_sym = 0; m_err = 0;
      ref_q.delete();
      return;
    end
    if (start && !m_run) begin
      m_run = 1; m_done = 0; m_ovf = 0; m_unf = 0;
      m_sym = 0; m_err = 0; m_mode = mode;
      ref_q.delete();
      return;
    end
    if (rx_valid) begin
      d = slice(m_mode, rx_real, rx_imag);
      exp_q.push_back(d);
      if (m_run) begin
        if (ref_q.size() == 0) m_unf = 1;
        else begin
          r = ref_q.pop_front();
          m_sym++;
          m_err += nerr(d, r, m_mode);
          if (m_sym == NSYM) begin m_run = 0; m_done = 1; end
        end
      end
    end
    if (tx_valid) begin
      if (ref_q.size() < DEPTH) ref_q.push_back(tx_bits);
      else m_ovf = 1;
    end
  endtask

  task automatic cyc(input logic rn, input logic st, input logic md, input logic tv,
                     input logic [3:0] tb, input logic rv, input int ii, input int qq);
    @(negedge clk);
    reset = rn; start = st; mode = md; tx_valid = tv; tx_bits = tb; rx_valid = rv;
    rx_real = ii[BI-1:0];
    rx_imag = qq[BI-1:0];
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 0, 0, 4'h0, 0, 0, 0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_sym_cnt"}, sym_cnt, m_sym);
    chk({tag, "_err_cnt"}, err_cnt, m_err);
    chk({tag, "_busy"}, busy, m_run);
    chk({tag, "_done"}, done, m_done);
    chk({tag, "_fifo_ovf"}, fifo_ovf, m_ovf);
    chk({tag, "_fifo_unf"}, fifo_unf, m_unf);
  endtask

  task automatic run_random(input int n);
    cyc(1, 0, 0, 1, 4'($urandom), 0, 0, 0);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, k < n - 1, 4'($urandom), 1, pick(), pick());
  endtask

  // monitor: every presented decision is matched against the scoreboard
  always @(negedge clk) begin
    if (mon_en && dec_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dec_unexpected: actual=%0d required=none", dec_bits);
      end else begin
        chk("dec_bits", dec_bits, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int         ri[20];
    int         rq[20];
    logic [3:0] rb[20];
    logic [3:0] tmp;

    // reset state
    cyc(0, 0, 0, 0, 4'h0, 0, 0, 0);
    cyc(0, 0, 0, 0, 4'h0, 0, 0, 0);
    mon_en = 1;
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_bits", dec_bits, 0);
    check_all("rst");

    // decisions outside RUN are presented but not counted
    idle(1);
    cyc(1, 0, 0, 0, 4'h0, 1, 5, -5);
    idle(2);
    check_all("idle_rx");

    // run 1: QPSK, references match the decisions
    ri[0] = 5;  rq[0] = -5;
    ri[1] = -5; rq[1] = 5;
    ri[2] = -5; rq[2] = -5;
    ri[3] = 5;  rq[3] = 5;
    for (int k = 4; k < 20; k++) begin ri[k] = pick(); rq[k] = pick(); end
    for (int k = 0; k < 20; k++) rb[k] = slice(0, ri[k], rq[k]);
    cyc(1, 1, 0, 0, 4'h0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, rb[k], 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(1, 0, 0, k + 4 < 20, rb[(k + 4) % 20], 1, ri[k], rq[k]);
    idle(1);
    chk("run1_done_early", done, 0);
    idle(1);
    chk("run1_done_latency", done, 1);
    chk("run1_busy_off", busy, 0);
    idle(1);
    chk("run1_err_zero", err_cnt, 0);
    check_all("run1");

    // run 2: 16-QAM, restart from DONE, threshold and most-negative cases
    cyc(1, 1, 1, 0, 4'h0, 0, 0, 0);
    cyc(1, 0, 0, 1, 4'b0111, 0, 0, 0);
    cyc(1, 0, 0, 0, 4'h0, 1, 2097152, -2097151);
    idle(3);
    chk("qam_thr_err", err_cnt, 1);
    cyc(1, 0, 0, 1, 4'($urandom), 0, 0, 0);
    cyc(1, 0, 0, 0, 4'h0, 1, -8388608, pick());
    idle(1);
    chk("most_neg_bits32", dec_bits[3:2], 3);
    run_random(18);
    idle(3);
    check_all("run2");

    // run 3: overflow, push+pop while full, underflow
    cyc(1, 1, 1'($urandom), 0, 4'h0, 0, 0, 0);
    for (int k = 0; k < 17; k++) cyc(1, 0, 0, 1, 4'($urandom), 0, 0, 0);
    idle(1);
    chk("fifo_ovf_set", fifo_ovf, m_ovf);
    chk("fifo_ovf_unf_clear", fifo_unf, m_unf);
    cyc(1, 0, 0, 1, 4'($urandom), 1, pick(), pick());
    for (int k = 0; k < 16; k++) cyc(1, 0, 0, 0, 4'h0, 1, pick(), pick());
    cyc(1, 0, 0, 0, 4'h0, 1, pick(), pick());
    idle(3);
    check_all("fifo");
    run_random(3);
    idle(3);
    check_all("fifo_end");

    // run 4: reset mid-run with an erroring symbol in stage 2
    cyc(1, 1, 1, 0, 4'h0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      ri[k] = pick(); rq[k] = pick();
      tmp = slice(1, ri[k], rq[k]);
      cyc(1, 0, 0, 1, ~tmp, 0, 0, 0);
    end
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 4'h0, 1, ri[k], rq[k]);
    cyc(0, 0, 0, 0, 4'h0, 0, 0, 0);
    cyc(1, 0, 0, 0, 4'h0, 0, 0, 0);
    chk("midrst_dec_valid", dec_valid, 0);
    chk("midrst_dec_bits", dec_bits, 0);
    check_all("midrst");

    // run 5: clean run after reset, with an ignored start mid-run
    cyc(1, 1, 0, 0, 4'h0, 0, 0, 0);
    run_random(10);
    cyc(1, 1, 1, 0, 4'h0, 0, 0, 0);
    run_random(10);
    idle(3);
    check_all("run5");

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qam_slicer_ber.md
Name: qam_slicer_ber

Overview:
Receive-side stage directly downstream of the AWGN channel model. It hard-decision slices noisy 24-bit I/Q samples into QPSK or 16-QAM Gray-coded bits. It also aligns each sample with the transmitted bits, which are buffered in an internal reference FIFO, and accumulates symbol and bit-error counts for BER measurement. A run ends after a programmed number of symbols, and the final counts are held until the next start.

Parameters:
BI, 24, I/Q sample width (signed two's complement)
AMP, 24'sd1048576, 16-QAM unit amplitude A; decision thresholds at 0 and ±2A
NSYM, 320000, symbols per measurement run
FIFO_DEPTH, 16, reference-bit FIFO depth (power of 2)
CW, 32, counter width

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  one-cycle pulse that begins a run
mode  in  1  0 = QPSK (bits[1:0] only), 1 = 16-QAM; sampled on start
tx_valid  in  1  push tx_bits into the reference FIFO
tx_bits  in  4  transmitted symbol bits
rx_valid  in  1  rx sample valid
rx_real  in  BI  received I, signed
rx_imag  in  BI  received Q, signed
dec_valid  out  1  decision valid
dec_bits  out  4  sliced bits
sym_cnt  out  CW  symbols compared this run
err_cnt  out  CW  bit errors this run
busy  out  1  high in RUN
done  out  1  high in DONE
fifo_ovf  out  1  sticky: push was dropped
fifo_unf  out  1  sticky: rx arrived with FIFO empty

Behaviour:
- Reset is synchronous, active-low, on signal reset; clock is clk.
- Reset state: every output is 0; FSM in IDLE; FIFO empty.
- FSM states:
  - IDLE: start moves to RUN. On the same edge, clear sym_cnt, err_cnt, fifo_ovf, fifo_unf, flush the FIFO, and latch mode.
  - RUN: busy = 1. When the symbol being counted makes sym_cnt equal NSYM, move to DONE.
  - DONE: done = 1 and the counters are frozen. start moves back to RUN with the same clears as from IDLE.
  - start while in RUN is ignored.
- FIFO behaviour:
  - A push accepts tx_bits when tx_valid = 1 and the FIFO is not full, in any state.
  - A push when full drops the data and sets fifo_ovf.
  - A pop happens when rx_valid = 1 in RUN.
  - Simultaneous push and pop while full is legal: the pop frees the slot, nothing is dropped, and occupancy is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Occupancy is tracked with a log2(FIFO_DEPTH)+1 bit counter.
- Pipeline stage 1 (registered; edge after rx_valid):
  - Form |I| and |Q| in BI+1 bits so the most negative input is handled correctly.
  - QPSK: bit1 = I<0, bit0 = Q<0; bits[3:2] are 0.
  - 16-QAM: bit3 = I<0, bit2 = |I|>=2A, bit1 = Q<0, bit0 = |Q|>=2A.
  - A value of exactly 0 decides as positive. A magnitude of exactly 2A decides as the outer point.
  - The popped reference bits are registered alongside the decision.
  - dec_valid = 1 and dec_bits are presented in this cycle.
- rx_valid in RUN with the FIFO empty:
  - Set fifo_unf.
  - Still produce a decision, but do not count it and do not pop.
- Pipeline stage 2 (edge after dec_valid, only when the symbol is counted):
  - err = popcount(dec_bits XOR ref), masked to bits[1:0] in QPSK.
  - sym_cnt += 1; err_cnt += err.
  - Both counters saturate at all-ones.
- dec_valid and dec_bits are also produced outside RUN when rx_valid = 1, but nothing is popped or counted.
- Reset asserted mid-run aborts immediately. Counters clear and stage-1/2 results in flight are discarded.
- Latency: rx_valid to dec_valid is 1 cycle; rx_valid to counter update is 2 cycles; the last counted symbol to done is 2 cycles.

Optional Feature:
- Macro: QAM_SLICER_PERBIT_ERR_EN.
- Defined:
  - Adds output err_bit_cnt, 4*CW bits: four per-bit-position error counters, saturating.
  - They are cleared and frozen exactly like err_cnt.
  - Their sum equals err_cnt until saturation.
- Undefined: the port and its logic are absent.

Decomposition:
- Package qam_pkg: MODE_QPSK and MODE_16QAM constants, the FSM state enum (IDLE, RUN, DONE), and a popcount4 function.
- One sub-module, ref_bit_fifo: a parameterised sync FIFO with full/empty flags and drop-on-full.
- The slicer, compare and counters stay in the top level.

Test Plan:
- Reset, then start with mode=0, NSYM=4. Push 4'b0001, 0010, 0011, 0000. Drive rx (I,Q) = (+5,−5), (−5,+5), (−5,−5), (+5,+5). Required: err_cnt=0, sym_cnt=4, done asserts 2 cycles after the last rx, busy=0.
- mode=1, A=1048576. rx (I,Q) = (2097152, −2097151) with ref 4'b0111. Required: dec_bits=4'b0110, err_cnt=1.
- rx_real = −8388608 (most negative), mode=1. Required: bit3=1, bit2=1, no overflow artifact.
- Push 17 entries with no pops. Required: fifo_ovf=1 and the 17th entry is dropped. Then push and pop simultaneously while full. Required: occupancy stays 16 and fifo_ovf gets no new event.
- rx_valid in RUN with the FIFO empty. Required: fifo_unf=1, sym_cnt unchanged, dec_valid=1.
- Assert reset low mid-run after 3 symbols with errors pending in stage 2. Required: all outputs 0 next cycle; a subsequent start runs cleanly from 0.
